// File: rtl/hs_npu_gatekeeper_sequencer.sv
// hs_npu_gatekeeper_sequencer
//
// Sequences the NPU feed path: input FIFO -> chained gatekeeper stages ->
// output FIFO. It accepts a job (cycles per round, number of rounds). For
// each round it waits for data and sink space, fires a one-cycle start into
// gatekeeper stage 0, runs for `cycles` cycles and then drains the chain for
// STAGES cycles. When the last round has drained it reports completion. An
// abort flushes both FIFOs and returns the block to idle.
//
// Ports
//   clk_core, rst_core_n       core clock, async active-low reset
//   cmd_valid_i / cmd_ready_o  command handshake (ready only in IDLE)
//   cmd_cycles_i, cmd_rounds_i job parameters, both must be non-zero
//   abort_i                    abort the running job
//   in_fifo_valid_i            input FIFO has data
//   out_fifo_ready_i           output FIFO has space
//   gk_start_o                 start pulse to gatekeeper stage 0
//   gk_enable_cycles_o         latched enable-cycle count for all stages
//   fifo_flush_o               flush pulse to both FIFOs (on abort)
//   busy_o, round_o            job in progress, current 0-based round
//   done_o, err_o, aborted_o   completion / illegal command / abort ack pulses
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a command; illegal commands answered with err_o
// ARM   | waiting for input data and output space, then start pulse
// RUN   | gatekeeper chain active for the latched number of cycles
// DRAIN | STAGES cycles for the start to ripple through the chain
// DONE  | one-cycle completion pulse, back to IDLE

module hs_npu_gatekeeper_sequencer #(
    parameter int STAGES  = 2,
    parameter int CNT_W   = 32,
    parameter int ROUND_W = 8
) (
    input  logic               clk_core,
    input  logic               rst_core_n,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic [CNT_W-1:0]   cmd_cycles_i,
    input  logic [ROUND_W-1:0] cmd_rounds_i,
    input  logic               abort_i,
    input  logic               in_fifo_valid_i,
    input  logic               out_fifo_ready_i,
    output logic               gk_start_o,
    output logic [CNT_W-1:0]   gk_enable_cycles_o,
    output logic               fifo_flush_o,
    output logic               busy_o,
    output logic [ROUND_W-1:0] round_o,
    output logic               done_o,
    output logic               err_o,
    output logic               aborted_o
);

    localparam int DW = $clog2(STAGES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   run_cnt_q;
    logic [DW-1:0]      drain_cnt_q;
    logic [ROUND_W-1:0] rounds_q;
    logic [ROUND_W-1:0] round_q;
    logic [CNT_W-1:0]   enable_cycles_q;
    logic               err_q;
    logic               abort_q;

    logic cmd_fire;
    logic cmd_bad;
    logic start_ok;
    logic run_last;
    logic drain_last;
    logic more_rounds;
    logic abort_take;

    assign cmd_fire   = (state_q == S_IDLE) && cmd_valid_i;
    assign cmd_bad    = (cmd_cycles_i == '0) || (cmd_rounds_i == '0);
    assign start_ok   = in_fifo_valid_i && out_fifo_ready_i;
    assign run_last   = (run_cnt_q == CNT_W'(1));
    assign drain_last = (drain_cnt_q == DW'(1));
    // One extra bit so the compare cannot overflow at the top of the range.
    assign more_rounds = ({1'b0, round_q} + (ROUND_W+1)'(1)) < {1'b0, rounds_q};
    // Abort is honoured only while a job is actually running; in DONE the
    // job has already completed and the completion pulse takes precedence.
    assign abort_take = abort_i &&
                        ((state_q == S_ARM) || (state_q == S_RUN) || (state_q == S_DRAIN));

    always_ff @(posedge clk_core or negedge rst_core_n) begin
        if (!rst_core_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        gk_start_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i && !cmd_bad) begin
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else if (start_ok) begin
                    gk_start_o = 1'b1;
                    state_d    = S_RUN;
                end
            end
            S_RUN: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else if (run_last) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else if (drain_last) begin
                    state_d = more_rounds ? S_ARM : S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_core or negedge rst_core_n) begin
        if (!rst_core_n) begin
            run_cnt_q       <= '0;
            drain_cnt_q     <= '0;
            rounds_q        <= '0;
            round_q         <= '0;
            enable_cycles_q <= '0;
            err_q           <= 1'b0;
            abort_q         <= 1'b0;
        end else begin
            err_q   <= cmd_fire && cmd_bad;
            abort_q <= abort_take;

            if (cmd_fire && !cmd_bad) begin
                enable_cycles_q <= cmd_cycles_i;
                rounds_q        <= cmd_rounds_i;
                round_q         <= '0;
            end

            if (gk_start_o) begin
                run_cnt_q <= enable_cycles_q;
            end else if (state_q == S_RUN) begin
                run_cnt_q <= run_cnt_q - CNT_W'(1);
            end

            if ((state_q == S_RUN) && run_last) begin
                drain_cnt_q <= DW'(STAGES);
            end else if (state_q == S_DRAIN) begin
                drain_cnt_q <= drain_cnt_q - DW'(1);
            end

            if ((state_q == S_DRAIN) && !abort_i && drain_last && more_rounds) begin
                round_q <= round_q + ROUND_W'(1);
            end
        end
    end

    assign cmd_ready_o        = (state_q == S_IDLE);
    assign busy_o             = (state_q != S_IDLE);
    assign done_o             = (state_q == S_DONE);
    assign err_o              = err_q;
    assign aborted_o          = abort_q;
    assign fifo_flush_o       = abort_q;
    assign round_o            = round_q;
    assign gk_enable_cycles_o = enable_cycles_q;

endmodule

// File: tb/tb_hs_npu_gatekeeper_sequencer.sv
// Testbench for hs_npu_gatekeeper_sequencer: directed scenarios with
// literal timing expectations, then randomized traffic, all checked every
// cycle against a job-level timeline model.

module tb_hs_npu_gatekeeper_sequencer;

    localparam int STAGES  = 2;
    localparam int CNT_W   = 32;
    localparam int ROUND_W = 8;

    logic               clk_core = 1'b0;
    logic               rst_core_n = 1'b0;
    logic               cmd_valid_i = 1'b0;
    logic               cmd_ready_o;
    logic [CNT_W-1:0]   cmd_cycles_i = '0;
    logic [ROUND_W-1:0] cmd_rounds_i = '0;
    logic               abort_i = 1'b0;
    logic               in_fifo_valid_i = 1'b0;
    logic               out_fifo_ready_i = 1'b0;
    logic               gk_start_o;
    logic [CNT_W-1:0]   gk_enable_cycles_o;
    logic               fifo_flush_o;
    logic               busy_o;
    logic [ROUND_W-1:0] round_o;
    logic               done_o;
    logic               err_o;
    logic               aborted_o;

    hs_npu_gatekeeper_sequencer #(
        .STAGES (STAGES),
        .CNT_W  (CNT_W),
        .ROUND_W(ROUND_W)
    ) dut (
        .clk_core          (clk_core),
        .rst_core_n        (rst_core_n),
        .cmd_valid_i       (cmd_valid_i),
        .cmd_ready_o       (cmd_ready_o),
        .cmd_cycles_i      (cmd_cycles_i),
        .cmd_rounds_i      (cmd_rounds_i),
        .abort_i           (abort_i),
        .in_fifo_valid_i   (in_fifo_valid_i),
        .out_fifo_ready_i  (out_fifo_ready_i),
        .gk_start_o        (gk_start_o),
        .gk_enable_cycles_o(gk_enable_cycles_o),
        .fifo_flush_o      (fifo_flush_o),
        .busy_o            (busy_o),
        .round_o           (round_o),
        .done_o            (done_o),
        .err_o             (err_o),
        .aborted_o         (aborted_o)
    );

    always #5 clk_core = ~clk_core;

    int vectors = 0;
    int miscompares = 0;

    // Job-level model. A job is either waiting for its start condition or
    // running toward an absolute boundary cycle computed from the timing
    // rule (start + cycles + STAGES + 1), then either re-arms or completes.
    localparam int P_IDLE = 0, P_WAIT = 1, P_BUSY = 2, P_FIN = 3;
    int          m_phase;
    longint      m_end;
    longint      m_cycles;
    int          m_rounds;
    int          m_round;
    bit          m_err;
    bit          m_abt;
    longint      cyc = 0;

    // Event log for the directed scenarios, relative to the mark.
    longint base = 0;
    int     dut_starts[$];
    int     dut_start_rounds[$];
    int     dut_done_at, dut_abort_at, dut_err_at, mdl_done_at;

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_phase  = P_IDLE;
        m_end    = 0;
        m_cycles = 0;
        m_rounds = 0;
        m_round  = 0;
        m_err    = 0;
        m_abt    = 0;
    endtask

    task automatic mark();
        base = cyc;
        dut_starts.delete();
        dut_start_rounds.delete();
        dut_done_at  = -1;
        dut_abort_at = -1;
        dut_err_at   = -1;
        mdl_done_at  = -1;
    endtask

    task automatic check_outputs();
        bit e_start;
        int rel;
        e_start = (m_phase == P_WAIT) && in_fifo_valid_i && out_fifo_ready_i && !abort_i;
        chk("cmd_ready", cmd_ready_o, m_phase == P_IDLE);
        chk("busy", busy_o, m_phase != P_IDLE);
        chk("gk_start", gk_start_o, e_start);
        chk("done", done_o, m_phase == P_FIN);
        chk("err", err_o, m_err);
        chk("aborted", aborted_o, m_abt);
        chk("fifo_flush", fifo_flush_o, m_abt);
        chk("round", round_o, m_round);
        chk("enable_cycles", gk_enable_cycles_o, m_cycles);
        rel = int'(cyc - base);
        if (gk_start_o) begin
            dut_starts.push_back(rel);
            dut_start_rounds.push_back(int'(round_o));
        end
        if (done_o && dut_done_at < 0) dut_done_at = rel;
        if (aborted_o && dut_abort_at < 0) dut_abort_at = rel;
        if (err_o && dut_err_at < 0) dut_err_at = rel;
        if (m_phase == P_FIN && mdl_done_at < 0) mdl_done_at = rel;
    endtask

    // Advance the model across one clock edge using the inputs that were
    // present during cycle `cyc`.
    task automatic model_step(input bit v, input longint c, input int r,
                              input bit ab, input bit iv, input bit orr);
        bit n_err, n_abt;
        n_err = 0;
        n_abt = 0;
        if (!rst_core_n) begin
            model_reset();
            return;
        end
        case (m_phase)
            P_IDLE: begin
                if (v) begin
                    if (c == 0 || r == 0) begin
                        n_err = 1;
                    end else begin
                        m_cycles = c;
                        m_rounds = r;
                        m_round  = 0;
                        m_phase  = P_WAIT;
                    end
                end
            end
            P_FIN: m_phase = P_IDLE;
            default: begin
                if (ab) begin
                    m_phase = P_IDLE;
                    n_abt   = 1;
                end else if (m_phase == P_WAIT) begin
                    if (iv && orr) begin
                        m_end   = cyc + m_cycles + STAGES + 1;
                        m_phase = P_BUSY;
                    end
                end else if (cyc + 1 == m_end) begin
                    if (m_round + 1 < m_rounds) begin
                        m_round++;
                        m_phase = P_WAIT;
                    end else begin
                        m_phase = P_FIN;
                    end
                end
            end
        endcase
        m_err = n_err;
        m_abt = n_abt;
    endtask

    // One cycle: drive inputs, check at the falling edge, step at the rise.
    task automatic tick(input bit v, input longint c, input int r,
                        input bit ab, input bit iv, input bit orr);
        cmd_valid_i      = v;
        cmd_cycles_i     = CNT_W'(c);
        cmd_rounds_i     = ROUND_W'(r);
        abort_i          = ab;
        in_fifo_valid_i  = iv;
        out_fifo_ready_i = orr;
        @(negedge clk_core);
        check_outputs();
        @(posedge clk_core);
        #1;
        model_step(v, c, r, ab, iv, orr);
        cyc++;
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 1, 1);
    endtask

    initial begin
        model_reset();
        mark();
        idle_ticks(2);
        rst_core_n = 1'b1;

        // Basic single-round job.
        mark();
        tick(1, 3, 1, 0, 1, 1);
        idle_ticks(9);
        chk("basic_start_count", dut_starts.size(), 1);
        if (dut_starts.size() > 0) chk("basic_start_cycle", dut_starts[0], 1);
        chk("basic_done_cycle", dut_done_at, 7);
        chk("basic_model_done", mdl_done_at, 7);

        // Illegal commands keep the previous enable count.
        mark();
        tick(1, 0, 1, 0, 1, 1);
        idle_ticks(2);
        chk("illegal_cycles_err", dut_err_at, 1);
        chk("illegal_cycles_enable", gk_enable_cycles_o, 3);
        mark();
        tick(1, 5, 0, 0, 1, 1);
        idle_ticks(2);
        chk("illegal_rounds_err", dut_err_at, 1);
        chk("illegal_rounds_enable", gk_enable_cycles_o, 3);
        chk("illegal_no_start", dut_starts.size(), 0);

        // Multi-round job: starts every cycles+STAGES+1 edges.
        mark();
        tick(1, 2, 3, 0, 1, 1);
        idle_ticks(18);
        chk("multi_start_count", dut_starts.size(), 3);
        for (int i = 0; i < 3 && i < dut_starts.size(); i++) begin
            chk("multi_start_cycle", dut_starts[i], 1 + 5 * i);
            chk("multi_start_round", dut_start_rounds[i], i);
        end
        chk("multi_done_cycle", dut_done_at, 16);
        chk("multi_model_done", mdl_done_at, 16);

        // Back-pressure on both FIFOs.
        mark();
        tick(1, 4, 1, 0, 0, 0);
        for (int rel = 1; rel <= 16; rel++) tick(0, 0, 0, 0, rel >= 5, rel >= 7);
        if (dut_starts.size() > 0) chk("bp_start_cycle", dut_starts[0], 7);
        chk("bp_done_cycle", dut_done_at, 14);

        // Abort during RUN.
        mark();
        tick(1, 10, 2, 0, 1, 1);
        idle_ticks(3);
        tick(0, 0, 0, 1, 1, 1);
        idle_ticks(4);
        chk("abort_run_ack", dut_abort_at, 5);
        chk("abort_run_no_done", dut_done_at, -1);

        // Abort in ARM coincident with the start condition.
        mark();
        tick(1, 3, 1, 0, 0, 0);
        tick(0, 0, 0, 1, 1, 1);
        idle_ticks(3);
        chk("abort_arm_no_start", dut_starts.size(), 0);
        chk("abort_arm_ack", dut_abort_at, 2);

        // Abort in DONE is ignored.
        mark();
        tick(1, 1, 1, 0, 1, 1);
        idle_ticks(4);
        tick(0, 0, 0, 1, 1, 1);
        idle_ticks(2);
        chk("abort_done_done", dut_done_at, 5);
        chk("abort_done_no_ack", dut_abort_at, -1);

        // Async reset while draining, then a fresh job.
        mark();
        tick(1, 3, 1, 0, 1, 1);
        idle_ticks(5);
        #2;
        rst_core_n = 1'b0;
        #1;
        model_reset();
        chk("rst_busy", busy_o, 0);
        chk("rst_ready", cmd_ready_o, 1);
        check_outputs();
        idle_ticks(2);
        rst_core_n = 1'b1;
        mark();
        tick(1, 1, 1, 0, 1, 1);
        idle_ticks(6);
        chk("post_rst_done", dut_done_at, 5);
        chk("no_flush_on_rst", dut_abort_at, -1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            bit     v, ab, iv, orr;
            longint c;
            int     r;
            v   = ($urandom % 4) == 0;
            c   = (($urandom % 8) == 0) ? 0 : longint'($urandom_range(1, 6));
            r   = (($urandom % 8) == 0) ? 0 : int'($urandom_range(1, 3));
            ab  = ($urandom % 40) == 0;
            iv  = ($urandom % 4) != 0;
            orr = ($urandom % 4) != 0;
            tick(v, c, r, ab, iv, orr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
